// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (D), one access in flight.
// Optional response timeout is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int unsigned STW = 8;
   localparam int unsigned TW  = 16;
   localparam logic [STW-1:0] STREAK_MAX = STW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]    mem_wstrb_q, mem_wstrb_d;
   logic [STW-1:0]   streak_q, streak_d;
   logic             rsp_ok, tmo_hit, done, d_win;

   assign rsp_ok = (state_q == ST_RESP) && mem_rvalid;
   assign done   = rsp_ok || tmo_hit;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // A real response in the timeout cycle wins over the timeout.
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_LAST) && !rsp_ok;
   assign tmo_d   = (state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);

   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cfg;
   assign tmo_hit        = 1'b0;
   assign unused_tmo_cfg = ^TW'(TIMEOUT_CYCLES);
`endif

   // Data wins unless fetch has waited out a full streak.
   assign d_win = d_req && !(if_req && (streak_q >= STREAK_MAX));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      streak_d    = streak_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               state_d   = ST_REQ;
               mem_req_d = 1'b1;
               if (d_win) begin
                  owner_d     = OWN_D;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_wstrb_d = d_wstrb;
                  if (if_req)
                     streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + STW'(1);
               end else begin
                  owner_d     = OWN_IF;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  mem_wstrb_d = '0;
                  streak_d    = '0;
               end
            end
         end
         ST_REQ: begin
            if (tmo_hit) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end else if (mem_gnt) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
            end
         end
         ST_RESP: begin
            if (done) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         streak_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         streak_q    <= streak_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

   assign if_rvalid = done && (owner_q == OWN_IF);
   assign d_rvalid  = done && (owner_q == OWN_D);
   assign if_rdata  = (rsp_ok && (owner_q == OWN_IF)) ? mem_rdata : '0;
   assign d_rdata   = (rsp_ok && (owner_q == OWN_D)) ? mem_rdata : '0;
   assign if_err    = tmo_hit && (owner_q == OWN_IF);
   assign d_err     = tmo_hit && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model with a per-cycle output compare.
module tb_mem_port_arbiter;
   localparam int unsigned MAXS = 4;
   localparam int unsigned TMO  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        if_rvalid, if_err, d_rvalid, d_err;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } dtxn_t;

   logic [31:0] if_q[$];
   dtxn_t       d_q[$];

   int    tests = 0, fails = 0, cyc = 0;
   int    gd = 0, rd = 0;
   bit    stray_idle = 0, stray_req = 0, rst_cmd = 1;

   // Reference model: one transaction record, timed from its arbitration cycle.
   bit          m_busy = 0, m_own_d = 0;
   int          m_s = 0, m_gd = 0, m_rd = 0, streak = 0;
   logic        e_we = 0;
   logic [31:0] e_addr = '0, e_wdata = '0;
   logic [3:0]  e_wstrb = '0;
   string       glog = "";

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   function automatic bit timed_out();
`ifdef MEM_ARB_TIMEOUT_EN
      return (int'(TMO) < 2 + m_gd + m_rd);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int done_cyc();
      return timed_out() ? m_s + int'(TMO) : m_s + 2 + m_gd + m_rd;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%s required=%s", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step();
      bit          done, real_rsp, in_req, dwin;
      logic [31:0] x_rdata;
      @(negedge clk);
      rst     = rst_cmd;
      if_req  = (if_q.size() > 0);
      if_addr = (if_q.size() > 0) ? if_q[0] : '0;
      d_req   = (d_q.size() > 0);
      d_we    = (d_q.size() > 0) ? d_q[0].we : 1'b0;
      d_addr  = (d_q.size() > 0) ? d_q[0].addr : '0;
      d_wdata = (d_q.size() > 0) ? d_q[0].wdata : '0;
      d_wstrb = (d_q.size() > 0) ? d_q[0].wstrb : '0;
      in_req   = m_busy && cyc >= m_s + 1 && cyc <= m_s + 1 + m_gd && cyc <= done_cyc();
      done     = m_busy && cyc == done_cyc();
      real_rsp = done && !timed_out();
      mem_gnt    = m_busy && cyc == m_s + 1 + m_gd && cyc <= done_cyc();
      mem_rvalid = real_rsp || (stray_idle && !m_busy) || (stray_req && in_req);
      mem_rdata  = real_rsp ? mem_data(e_addr) : (32'hBAD0_0000 | 32'(cyc));
      #1;
      x_rdata = real_rsp ? mem_data(e_addr) : '0;
      chk("mem_req",   32'(mem_req),   32'(in_req));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  mem_addr,       e_addr);
      chk("mem_wdata", mem_wdata,      e_wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      chk("if_rvalid", 32'(if_rvalid), 32'(done && !m_own_d));
      chk("if_rdata",  if_rdata,       m_own_d ? 32'h0 : x_rdata);
      chk("if_err",    32'(if_err),    32'(done && !real_rsp && !m_own_d));
      chk("d_rvalid",  32'(d_rvalid),  32'(done && m_own_d));
      chk("d_rdata",   d_rdata,        m_own_d ? x_rdata : 32'h0);
      chk("d_err",     32'(d_err),     32'(done && !real_rsp && m_own_d));
      if (rst) begin
         m_busy = 0; streak = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
         if_q.delete(); d_q.delete();
      end else if (done) begin
         m_busy = 0;
         if (m_own_d) void'(d_q.pop_front());
         else         void'(if_q.pop_front());
      end else if (!m_busy && (if_q.size() > 0 || d_q.size() > 0)) begin
         dwin = d_q.size() > 0 && !(if_q.size() > 0 && streak == int'(MAXS));
         m_busy = 1; m_own_d = dwin; m_s = cyc; m_gd = gd; m_rd = rd;
         if (dwin) begin
            e_we = d_q[0].we; e_addr = d_q[0].addr; e_wdata = d_q[0].wdata; e_wstrb = d_q[0].wstrb;
            if (if_q.size() > 0 && streak < int'(MAXS)) streak++;
            glog = {glog, "D"};
         end else begin
            e_we = 0; e_addr = if_q[0]; e_wdata = '0; e_wstrb = '0;
            streak = 0;
            glog = {glog, "I"};
         end
      end
      cyc++;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((m_busy || if_q.size() > 0 || d_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      if (m_busy || if_q.size() > 0 || d_q.size() > 0) begin
         tests++; fails++;
         $display("FAIL %s_drain actual=busy after %0d cycles required=idle", name, budget);
      end
      step();
   endtask

   initial begin
      int n, first;
      @(posedge clk);
      step(); step();
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      rst_cmd = 0;
      step();

      // Single zero-wait fetch
      glog = "";
      if_q.push_back(32'h100);
      step(); step();
      chk("t1_mem_req", 32'(mem_req), 32'h1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_we", 32'(mem_we), 32'h0);
      step();
      chk("t1_if_rvalid", 32'(if_rvalid), 32'h1);
      chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
      drain("t1", 10);

      // Simultaneous store and fetch: store first
      glog = "";
      d_q.push_back(dtxn_t'{we: 1'b1, addr: 32'h200, wdata: 32'h12345678, wstrb: 4'hF});
      if_q.push_back(32'h104);
      step(); step();
      chk("t2_mem_we", 32'(mem_we), 32'h1);
      chk("t2_mem_addr", mem_addr, 32'h200);
      chk("t2_mem_wdata", mem_wdata, 32'h12345678);
      chk("t2_mem_wstrb", 32'(mem_wstrb), 32'hF);
      step();
      chk("t2_d_rvalid", 32'(d_rvalid), 32'h1);
      drain("t2", 20);
      chk_str("t2_grants", glog, "DI");

      // Continuous contention: streak limit lets fetch in every fifth grant
      glog = "";
      for (int i = 0; i < 8; i++)
         d_q.push_back(dtxn_t'{we: 1'(i & 1), addr: 32'h1000 + 32'(4 * i),
                               wdata: 32'hA000_0000 + 32'(i), wstrb: 4'(i + 1)});
      for (int i = 0; i < 2; i++) if_q.push_back(32'h2000 + 32'(4 * i));
      drain("t3", 60);
      chk_str("t3_grants", glog, "DDDDIDDDDI");

      // Stalled grant and response, stray responses while requesting
      gd = 3; rd = 2; stray_req = 1;
      d_q.push_back(dtxn_t'{we: 1'b0, addr: 32'h300, wdata: 32'h0, wstrb: 4'h0});
      step();
      n = 0; first = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (d_rvalid) begin
            n++;
            if (first < 0) first = k;
         end
      end
      chk("t4_latency", 32'(first), 32'd7);
      chk("t4_pulses", 32'(n), 32'd1);
      gd = 0; rd = 0; stray_req = 0;
      drain("t4", 10);

      // Stray responses while idle
      stray_idle = 1;
      for (int k = 0; k < 4; k++) step();
      stray_idle = 0;
      step();

`ifdef MEM_ARB_TIMEOUT_EN
      // Load that never gets a response times out, then a fetch proceeds normally
      rd = 1000;
      d_q.push_back(dtxn_t'{we: 1'b0, addr: 32'h400, wdata: 32'h0, wstrb: 4'h0});
      step();
      first = -1;
      for (int k = 1; k <= int'(TMO); k++) begin
         step();
         if (d_rvalid && first < 0) begin
            first = k;
            chk("t5_d_err", 32'(d_err), 32'h1);
            chk("t5_d_rdata", d_rdata, 32'h0);
         end
      end
      chk("t5_latency", 32'(first), 32'(TMO));
      rd = 0;
      step();
      chk("t5_mem_req", 32'(mem_req), 32'h0);
      if_q.push_back(32'h108);
      step(); step(); step();
      chk("t5_if_rvalid", 32'(if_rvalid), 32'h1);
      chk("t5_if_rdata", if_rdata, mem_data(32'h108));
      drain("t5", 10);
`endif

      // Reset in RESP aborts with no completion and clears the streak
      glog = ""; rd = 3;
      for (int i = 0; i < 4; i++)
         d_q.push_back(dtxn_t'{we: 1'b0, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
      if_q.push_back(32'h4000);
      n = 0;
      while (!(glog.len() == 4 && m_busy && cyc == m_s + 2) && n < 60) begin
         step();
         n++;
      end
      chk("t6_reached_resp", 32'(n < 60), 32'h1);
      rst_cmd = 1;
      step();
      rst_cmd = 0;
      step();
      chk("t6_mem_req", 32'(mem_req), 32'h0);
      chk("t6_d_rvalid", 32'(d_rvalid), 32'h0);
      rd = 0; glog = "";
      for (int i = 0; i < 8; i++)
         d_q.push_back(dtxn_t'{we: 1'b0, addr: 32'h5000 + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
      for (int i = 0; i < 2; i++) if_q.push_back(32'h6000 + 32'(4 * i));
      drain("t6", 60);
      chk_str("t6_grants", glog, "DDDDIDDDDI");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported instruction/data memory between the pipeline's fetch port and its load/store port. One transaction is outstanding at a time: data accesses win by default, and a streak counter keeps fetch from starving. The block sits between `pipeline_unit` (fetch address / `mem_write_addr` / `mem_write_data` / `cs_om`) and the memory model or bus bridge.

## Interface
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while fetch waits; range 1–255.
- `TIMEOUT_CYCLES`, default 64: response timeout; used only with the macro; range 2–65535.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_rvalid`.
- `if_addr` in 32: fetch word address.
- `if_rvalid` out 1: fetch completion, one cycle.
- `if_rdata` out 32: fetch data, valid with `if_rvalid`.
- `if_err` out 1: fetch timed out, valid with `if_rvalid`.
- `d_req` in 1: data request; held with its payload until `d_rvalid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: store byte enables.
- `d_rvalid` out 1: data completion (load data or store ack), one cycle.
- `d_rdata` out 32: load data.
- `d_err` out 1: data timed out.
- `mem_req` out 1: memory request, held until `mem_gnt`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out 1/32/32/4: registered payload.
- `mem_gnt` in 1: memory accepted the request this cycle.
- `mem_rvalid` in 1: memory response; issued for both loads and stores.
- `mem_rdata` in 32: response data.

## Operation
- FSM with three states: IDLE, REQ, RESP. A 1-bit `owner` register holds IF or D.
- IDLE, with any request present:
  - Latch the winner's payload into the `mem_*` registers and set `owner`.
  - Go to REQ.
  - A fetch payload is forced to `mem_we`=0, `mem_wstrb`=0, `mem_wdata`=0.
- Arbitration:
  - Only `d_req`: D wins.
  - Only `if_req`: IF wins.
  - Both: D wins unless `streak` == `MAX_DATA_STREAK`, in which case IF wins.
- Streak counter, 8 bits:
  - +1 when D wins while `if_req`=1; saturates at `MAX_DATA_STREAK`.
  - Clears to 0 whenever IF wins.
  - Unchanged when D wins with `if_req`=0.
- REQ:
  - `mem_req`=1 with the payload held stable.
  - On `mem_gnt`=1, drop `mem_req` at the next edge and go to RESP.
- RESP:
  - `mem_req`=0.
  - On `mem_rvalid`=1, the owner's `*_rvalid` is asserted combinationally in that same cycle and `*_rdata` = `mem_rdata`; then go to IDLE.
  - The non-owner's `*_rvalid` stays 0.
- Stray `mem_rvalid` in IDLE or REQ is discarded.
- `*_rdata` is 0 whenever the matching `*_rvalid`=0.
- A requester may change its payload or drop `req` only in the cycle after its `*_rvalid`. Arbitration samples `req` in IDLE only, so a requester that keeps `req` high immediately re-competes.

## Timing
- Reset: state IDLE, `owner` IF, `mem_req`=0, all `mem_*` payload 0, `streak`=0, timeout counter 0.
- Reset outputs: `if_rvalid`=0, `d_rvalid`=0, `if_err`=0, `d_err`=0.
- Reset mid-transaction aborts it with no completion pulse. The memory must also be reset.
- Zero-wait memory (`mem_gnt` in the first REQ cycle, `mem_rvalid` in the first RESP cycle):
  - Request seen in IDLE at cycle 0, `mem_req` in cycle 1, `*_rvalid` in cycle 2.
  - Next arbitration in cycle 3, so throughput is 1 access per 3 cycles.
- Each stall cycle of `mem_gnt` or `mem_rvalid` adds exactly one cycle.
- `mem_*` outputs are registered; `*_rvalid`, `*_rdata` and `*_err` are combinational from the memory response or the timeout.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`, defined:
  - A 16-bit counter clears on entry to REQ and increments every REQ/RESP cycle.
  - If it reaches `TIMEOUT_CYCLES` with no completion, the owner gets `*_rvalid`=1, `*_err`=1, `*_rdata`=0 that cycle.
  - `mem_req` drops at the next edge; FSM goes to IDLE.
  - A real `mem_rvalid` in the same cycle as the timeout takes precedence (err=0).
- Macro undefined: no counter; the block waits indefinitely; `if_err`=`d_err`=0 constantly.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x100 on zero-wait memory returning 0xDEADBEEF → `mem_req` in cycle 1 with `mem_addr`=0x100, `mem_we`=0; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in cycle 2.
- `if_req` and `d_req` asserted together (store 0x200, data 0x12345678, `wstrb`=0xF) → D served first with `mem_we`=1 and store ack on `d_rvalid`; IF served next.
- `d_req` and `if_req` held continuously, `MAX_DATA_STREAK`=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF.
- `mem_gnt` stalled 3 cycles, then `mem_rvalid` delayed 2 cycles → payload stable throughout; `*_rvalid` 5 cycles later than zero-wait; no duplicate pulse.
- Macro on, `TIMEOUT_CYCLES`=8, memory never responds to a load → `d_rvalid`=1, `d_err`=1, `d_rdata`=0 after 8 cycles; FSM back in IDLE; a following fetch completes normally.
- `rst` pulsed while in RESP → no `*_rvalid` pulse; `mem_req`=0 and `streak`=0 the next cycle.
